// File: rtl/wb16_master.sv
// wb16_master: Wishbone classic-cycle initiator on a 16-bit bus; 8/16/32-bit big-endian loads/stores.
// Define WB16_MASTER_TIMEOUT_EN to build the per-beat ack timeout (limit set by TIMEOUT_CYCLES).
module wb16_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  // Handshake: a request transfers on the rising clk_i edge where req_valid_i & req_ready_o are
  // both high; rsp_valid_o is a one-cycle pulse with no backpressure, rsp_* qualified by it.

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BEAT0 = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_BEAT1 = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:2] addr_hi_q;
  logic        addr_b0_q;
  logic [15:0] wdata_lo_q;
  logic [15:0] beat0_q;

  logic        accept;
  logic        misaligned;
  logic        ack_ok;
  logic        tmo_hit;
  logic        rsp_err_d;
  logic [31:0] rsp_rdata_d;
  logic [15:0] b0_dat_d;
  logic [1:0]  b0_sel_d;

  assign accept = req_valid_i & req_ready_o;
  // Acks seen while stb is low (stale registered acks) never advance the FSM.
  assign ack_ok = wb_ack_i & wb_stb_o;

  // size 1x is a word (11 aliases 10); bytes can never be misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (req_size_i[1]) misaligned = (req_addr_i[1:0] != 2'b00);
    else if (req_size_i[0]) misaligned = req_addr_i[0];
  end

  // First-beat lane select and write data, derived straight from the incoming request.
  always_comb begin
    b0_sel_d = 2'b11;
    b0_dat_d = req_wdata_i[15:0];
    if (req_size_i[1]) begin
      b0_dat_d = req_wdata_i[31:16];
    end else if (!req_size_i[0]) begin
      b0_sel_d = req_addr_i[0] ? 2'b01 : 2'b10;
      b0_dat_d = {2{req_wdata_i[7:0]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_BEAT0;
          end
        end
      end
      ST_BEAT0: begin
        if (ack_ok) begin
          if (size_q[1]) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_RESP;
            if (!we_q) begin
              if (size_q[0]) rsp_rdata_d = {16'h0000, wb_dat_i};
              else rsp_rdata_d = {24'h000000, addr_b0_q ? wb_dat_i[7:0] : wb_dat_i[15:8]};
            end
          end
        end else if (tmo_hit) begin
          state_d   = ST_RESP;
          rsp_err_d = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_BEAT1;
      end
      ST_BEAT1: begin
        if (ack_ok) begin
          state_d = ST_RESP;
          if (!we_q) rsp_rdata_d = {beat0_q, wb_dat_i};
        end else if (tmo_hit) begin
          state_d   = ST_RESP;
          rsp_err_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every output is registered from the next state so the bus is glitch-free and stable under stb.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      addr_hi_q   <= '0;
      addr_b0_q   <= 1'b0;
      wdata_lo_q  <= '0;
      beat0_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_o <= (state_d == ST_IDLE);
      wb_cyc_o    <= (state_d == ST_BEAT0) || (state_d == ST_GAP) || (state_d == ST_BEAT1);
      wb_stb_o    <= (state_d == ST_BEAT0) || (state_d == ST_BEAT1);
      rsp_valid_o <= (state_d == ST_RESP);
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rsp_rdata_d;

      if (accept) begin
        we_q       <= req_we_i;
        size_q     <= req_size_i;
        addr_hi_q  <= req_addr_i[31:2];
        addr_b0_q  <= req_addr_i[0];
        wdata_lo_q <= req_wdata_i[15:0];
      end

      if (accept && !misaligned) begin
        wb_adr_o <= {req_addr_i[31:1], 1'b0};
        wb_dat_o <= b0_dat_d;
        wb_sel_o <= b0_sel_d;
        wb_we_o  <= req_we_i;
      end

      if ((state_q == ST_BEAT0) && ack_ok) beat0_q <= wb_dat_i;

      // Second beat always carries the low half of the word at the odd halfword address.
      if (state_q == ST_GAP) begin
        wb_adr_o <= {addr_hi_q, 2'b10};
        wb_sel_o <= 2'b11;
        wb_dat_o <= wdata_lo_q;
      end

      if (state_d == ST_RESP) wb_we_o <= 1'b0;
    end
  end

`ifdef WB16_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] tmo_cnt_q;

  // Counts stb cycles without ack; the last allowed cycle is TIMEOUT_CYCLES-1 and an ack there still wins.
  assign tmo_hit = wb_stb_o && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (wb_stb_o && !wb_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // Without the timeout build the master waits for ack indefinitely.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: doc/wb16_master.md
Name: wb16_master

Overview:
- Wishbone classic-cycle initiator with a 16-bit data bus; the other end of the team's 16-bit Wishbone RAM/peripheral responders.
- Accepts one 8/16/32-bit big-endian load/store request at a time from a core-side port.
- Splits 32-bit accesses into two 16-bit beats under one continuous cyc.
- Returns read data and an error flag on a single-cycle response strobe.

Parameters:
- TIMEOUT_CYCLES, 64: ack wait limit per beat, in cycles. Used only with WB16_MASTER_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  32  load data, zero-extended; 0 for stores and errors.
- rsp_err_o  out  1  misaligned access or timeout; qualified by rsp_valid_o.
- wb_adr_o  out  32  bus address; bit 0 is always 0.
- wb_dat_o  out  16  write data.
- wb_dat_i  in  16  read data.
- wb_sel_o  out  2  lane select; [1] = bits 15:8 (even byte), [0] = bits 7:0.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  responder ack.

Behaviour:
- Reset (rst_i = 0 at a clock edge):
  - All outputs go to 0 and the FSM returns to IDLE, including mid-transfer.
  - No response is issued for an aborted request.
  - req_ready_o goes high on the first cycle after reset is released.
- FSM states: IDLE, BEAT0, GAP, BEAT1, RESP.
- IDLE:
  - req_ready_o = 1 only in this state.
  - On accept, latch we, size, addr and wdata.
  - Misaligned request (word with addr[1:0] != 0, or half with addr[0] = 1): go to RESP with err = 1 and issue no bus cycle.
  - Otherwise go to BEAT0.
- BEAT0:
  - cyc = stb = 1, we = latched we.
  - adr = {addr[31:1], 0}.
  - Byte: sel = 10 if addr[0] = 0, else 01. Write data is the byte replicated on both lanes.
  - Half: sel = 11, dat = wdata[15:0].
  - Word: sel = 11, dat = wdata[31:16].
  - On wb_ack_i: capture wb_dat_i. Word goes to GAP; other sizes go to RESP.
- GAP (word only):
  - Exactly one cycle; cyc = 1, stb = 0. adr, dat and sel are don't-care but held.
  - wb_ack_i is ignored, which tolerates responders that register ack from stb & cyc.
  - Next state is BEAT1.
- BEAT1:
  - cyc = stb = 1, adr = {addr[31:2], 10}, sel = 11, dat = wdata[15:0].
  - On ack: capture the low half, go to RESP.
- Exit from a beat:
  - cyc and stb drop in the cycle after the ack is sampled.
  - An ack asserted when stb = 0 is ignored in every state.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, cyc = stb = 0, then IDLE.
  - No request is accepted in this cycle.
- Read data formation (big-endian):
  - Word: {beat0, beat1}.
  - Half: {16'h0, beat0}.
  - Byte: {24'h0, beat0[15:8]} if addr[0] = 0, else {24'h0, beat0[7:0]}.
- Latency with a single-cycle-ack responder (ack registered from stb & cyc), accept in cycle 0:
  - Byte/half: stb in cycles 1–2, ack in cycle 2, rsp_valid_o in cycle 3.
  - Word: beat0 in cycles 1–2, GAP in cycle 3, beat1 in cycles 4–5, rsp_valid_o in cycle 6.
  - Misaligned: rsp_valid_o in cycle 1.
- Stability: wb_* outputs are registered and stable while stb = 1 until ack.

Optional Feature:
- Macro: WB16_MASTER_TIMEOUT_EN.
- When defined:
  - A per-beat counter clears on entry to BEAT0/BEAT1 and increments each stb cycle without ack.
  - Reaching TIMEOUT_CYCLES drops cyc/stb on the next edge and enters RESP with err = 1 and rdata = 0.
  - An ack arriving in the same cycle as expiry wins: normal completion.
- When undefined: no counter is built, the master waits indefinitely for ack, and rsp_err_o reports only misalignment.

Test Plan:
- Word store, addr 0x100, data 0xDEADBEEF:
  - Beat0: adr 0x100, dat 0xDEAD, sel 11, we 1.
  - GAP with stb 0, cyc 1.
  - Beat1: adr 0x102, dat 0xBEEF.
  - rsp_valid_o in cycle 6, err 0.
- Word load, addr 0x100, responder returns 0xDEAD then 0xBEEF: rsp_rdata_o = 0xDEADBEEF; the stale ack in GAP does not start beat1 early.
- Byte load, addr 0x101, wb_dat_i = 0x12AB: sel 01, rsp_rdata_o = 0x000000AB. Byte store, addr 0x100, data 0x5A: sel 10, dat 0x5A5A.
- Misaligned requests (half @0x103, word @0x102): no cyc ever asserted; rsp_valid_o in cycle 1 with err 1, rdata 0.
- Responder with 3 wait states, then rst_i = 0 during BEAT1 of a word load: cyc/stb are 0 on the next edge, no rsp_valid_o follows, req_ready_o = 1 after release.
- With WB16_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ack held at 0: stb is high for 4 cycles, then rsp_valid_o with err 1.
- Without WB16_MASTER_TIMEOUT_EN: stb stays high at least 100 cycles with no response.
